sram_phase_sequencer: RTL and testbench
=======================================

SRAM_PHASE_SEQUENCER -- requirements
Module: sram_phase_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data bits per SRAM word.
REQ-002 SHALL have parameter DEPTH, default 32, number of words and width of the one-hot word lines.
REQ-003 SHALL have parameter ABITS, default 5, binary address width, equal to log2(DEPTH).
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have ports req_valid in 1, req_ready out 1, req_write in 1, req_addrA in ABITS, req_addrB in ABITS, req_data in WIDTH: the request channel.
REQ-007 SHALL have ports wordA out DEPTH, wordB out DEPTH, in out WIDTH, ReadEn out 1, WriteEn out 1: drive the SRAM array.
REQ-008 SHALL have ports outA in WIDTH and outB in WIDTH: SRAM read data.
REQ-009 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_dataA out WIDTH, rsp_dataB out WIDTH, wr_done out 1, phase out 4.

Function
REQ-010 SHALL use FSM states IDLE, RUN and RESP.
REQ-011 SHALL drive req_ready=1 only in IDLE; a request is accepted on a clk edge where req_valid and req_ready are both 1, and all req_* fields are latched on that edge.
REQ-012 SHALL step phase 0..9, one clk per phase, in RUN; phase=0 in the cycle after acceptance; phase reads 0 outside RUN.
REQ-013 SHALL drive wordA = one-hot(addrA) and wordB = one-hot(addrB) while phase is 2..8, and all-zero otherwise.
REQ-014 SHALL drive in = latched data while phase is 4..8 for writes; in SHALL be 0 at all other times and for reads.
REQ-015 SHALL assert ReadEn for reads while phase is 6..7 only.
REQ-016 SHALL assert WriteEn for writes while phase is 8 only.
REQ-017 SHALL, for reads, register outA/outB into rsp_dataA/rsp_dataB on the edge that ends phase 7.
REQ-018 SHALL, at the end of phase 9, move a read to RESP and a write to IDLE; wr_done SHALL pulse for exactly one cycle, in the first IDLE cycle after a write.
REQ-019 SHALL hold rsp_valid=1 and stable rsp_data* in RESP until the first edge with rsp_ready=1, then return to IDLE.
REQ-020 SHALL accept no new request from acceptance until return to IDLE; back-to-back requests SHALL cost 11 cycles per write and at least 12 cycles per read.
REQ-021 SHALL let ReadEn and WriteEn never be 1 simultaneously.
REQ-022 SHALL drive identical values on wordA and wordB when addrA == addrB.

Reset
REQ-023 SHALL, while reset=0, immediately force the state to IDLE, phase to 0, and wordA, wordB, in, ReadEn, WriteEn, rsp_valid, rsp_data*, wr_done and req_ready to 0.
REQ-024 SHALL, on reset assertion mid-transaction, abandon the transaction with no response or wr_done; req_ready SHALL be 1 in the first cycle after release.

Configuration
REQ-025 SHALL, with macro SRAM_SEQ_WORDB_EN defined, support port B exactly as above.
REQ-026 SHALL, with SRAM_SEQ_WORDB_EN undefined, keep wordB=0 and rsp_dataB=0 at all times and ignore req_addrB; all other behaviour SHALL be unchanged.

Verification
REQ-027 SHALL verify: after reset release, write addrA=1, addrB=31, data 16'hAAAA -> wordA=32'h2, wordB=32'h80000000 during phases 2..8; in=16'hAAAA during phases 4..8; WriteEn=1 at phase 8 only; wr_done pulse 11 cycles after acceptance.
REQ-028 SHALL verify: read addrA=5, addrB=2 with outA=16'hABCD, outB=16'h1234 at phase 7 -> ReadEn high for phases 6..7, then rsp_valid=1 with rsp_dataA=16'hABCD, rsp_dataB=16'h1234.
REQ-029 SHALL verify: rsp_ready held 0 for 5 cycles -> rsp_valid and data stable, req_ready=0; rsp_ready=1 -> IDLE next cycle.
REQ-030 SHALL verify: reset=0 at phase 6 of a read -> all outputs 0 immediately, no rsp_valid; req_ready=1 in the first cycle after release.
REQ-031 SHALL verify: a write with addrA=addrB=0 -> wordA=wordB=32'h1; and, with SRAM_SEQ_WORDB_EN undefined, a read of addrB=3 -> wordB=0 and rsp_dataB=0.
REQ-032 SHALL verify: req_valid held high continuously -> exactly one acceptance per 11 cycles for writes; ReadEn and WriteEn never both 1.

Source files
------------

// File: rtl/sram_phase_sequencer_if.sv
// Bus bundle between the SRAM phase sequencer and its environment: request
// channel, SRAM array drive/readback and response channel.
// slave = the sequencer's view, master = the requester/array side.
interface sram_phase_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32,
  parameter int ABITS = 5
);
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [ABITS-1:0] req_addrA;
  logic [ABITS-1:0] req_addrB;
  logic [WIDTH-1:0] req_data;
  logic [DEPTH-1:0] wordA;
  logic [DEPTH-1:0] wordB;
  logic [WIDTH-1:0] in;
  logic             ReadEn;
  logic             WriteEn;
  logic [WIDTH-1:0] outA;
  logic [WIDTH-1:0] outB;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_dataA;
  logic [WIDTH-1:0] rsp_dataB;
  logic             wr_done;
  logic [3:0]       phase;

  modport slave (
    input  req_valid, req_write, req_addrA, req_addrB, req_data,
    input  outA, outB, rsp_ready,
    output req_ready, wordA, wordB, in, ReadEn, WriteEn,
    output rsp_valid, rsp_dataA, rsp_dataB, wr_done, phase
  );

  modport master (
    output req_valid, req_write, req_addrA, req_addrB, req_data,
    output outA, outB, rsp_ready,
    input  req_ready, wordA, wordB, in, ReadEn, WriteEn,
    input  rsp_valid, rsp_dataA, rsp_dataB, wr_done, phase
  );
endinterface

// File: rtl/sram_phase_sequencer.sv
// sram_phase_sequencer: runs one SRAM access as a fixed ten-phase sequence
// (phase 0..9), driving one-hot word lines, write data and read/write enables,
// then returns read data on a valid/ready response channel.
// Optional macro SRAM_SEQ_WORDB_EN enables the second word-line port (B);
// without it wordB and rsp_dataB stay zero and req_addrB/outB are ignored.
module sram_phase_sequencer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32,
  parameter int ABITS = 5
) (
  input logic                   clk,
  input logic                   reset,
  sram_phase_sequencer_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] LAST_PHASE = 4'd9;
  localparam logic [3:0] SAMPLE_PHASE = 4'd7;

  logic [1:0]       state;
  logic [3:0]       phaseCnt;
  logic             latchWrite;
  logic [ABITS-1:0] latchAddrA;
  logic [WIDTH-1:0] latchData;
  logic [WIDTH-1:0] rspDataA;
  logic             wrDone;
  logic             readyInt;
  logic             accept;
  logic             inRun;
  logic             wordPhase;
  logic             dataPhase;
`ifdef SRAM_SEQ_WORDB_EN
  logic [ABITS-1:0] latchAddrB;
  logic [WIDTH-1:0] rspDataB;
`else
  logic             unusedPortB;
`endif

  function automatic logic [DEPTH-1:0] oneHot(input logic [ABITS-1:0] addr);
    logic [DEPTH-1:0] lines;
    lines       = '0;
    lines[addr] = 1'b1;
    return lines;
  endfunction

  // Ready is gated by reset so it reads 0 while reset is held low.
  assign readyInt  = reset && (state == IDLE);
  assign accept    = bus.req_valid && readyInt;
  assign inRun     = (state == RUN);
  assign wordPhase = inRun && (phaseCnt >= 4'd2) && (phaseCnt <= 4'd8);
  assign dataPhase = inRun && latchWrite && (phaseCnt >= 4'd4) && (phaseCnt <= 4'd8);

  assign bus.req_ready = readyInt;
  assign bus.wordA     = wordPhase ? oneHot(latchAddrA) : '0;
  assign bus.in        = dataPhase ? latchData : '0;
  assign bus.ReadEn    = inRun && !latchWrite && ((phaseCnt == 4'd6) || (phaseCnt == 4'd7));
  assign bus.WriteEn   = inRun && latchWrite && (phaseCnt == 4'd8);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_dataA = rspDataA;
  assign bus.wr_done   = wrDone;
  assign bus.phase     = phaseCnt;
`ifdef SRAM_SEQ_WORDB_EN
  assign bus.wordB     = wordPhase ? oneHot(latchAddrB) : '0;
  assign bus.rsp_dataB = rspDataB;
`else
  assign bus.wordB     = '0;
  assign bus.rsp_dataB = '0;
  assign unusedPortB   = ^{bus.req_addrB, bus.outB};
`endif

  // Control FSM: IDLE -> RUN (phases 0..9) -> IDLE for writes, RESP for reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      phaseCnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          phaseCnt <= 4'd0;
          if (accept) state <= RUN;
        end
        RUN: begin
          if (phaseCnt == LAST_PHASE) begin
            phaseCnt <= 4'd0;
            state    <= latchWrite ? IDLE : RESP;
          end else begin
            phaseCnt <= phaseCnt + 4'd1;
          end
        end
        RESP: begin
          phaseCnt <= 4'd0;
          if (bus.rsp_ready) state <= IDLE;
        end
        default: begin
          phaseCnt <= 4'd0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Request fields are captured on acceptance; outputs are gated by state, so no reset is needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      latchWrite <= bus.req_write;
      latchAddrA <= bus.req_addrA;
      latchData  <= bus.req_data;
`ifdef SRAM_SEQ_WORDB_EN
      latchAddrB <= bus.req_addrB;
`endif
    end
  end

  // Read data is sampled from the array on the edge that ends phase 7.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rspDataA <= '0;
`ifdef SRAM_SEQ_WORDB_EN
      rspDataB <= '0;
`endif
    end else if (inRun && !latchWrite && (phaseCnt == SAMPLE_PHASE)) begin
      rspDataA <= bus.outA;
`ifdef SRAM_SEQ_WORDB_EN
      rspDataB <= bus.outB;
`endif
    end
  end

  // wr_done pulses for the first IDLE cycle after a write finishes phase 9.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrDone <= 1'b0;
    end else begin
      wrDone <= inRun && latchWrite && (phaseCnt == LAST_PHASE);
    end
  end

endmodule

// File: tb/tb_sram_phase_sequencer.sv
// Self-checking bench for sram_phase_sequencer. A scoreboard queue holds the
// expected completion (wr_done or read response) for every issued request.
module tb_sram_phase_sequencer;
  localparam int WIDTH = 16;
  localparam int DEPTH = 32;
  localparam int ABITS = 5;
`ifdef SRAM_SEQ_WORDB_EN
  localparam bit BEN = 1'b1;
`else
  localparam bit BEN = 1'b0;
`endif

  typedef struct {
    bit          isWrite;
    logic [15:0] dA;
    logic [15:0] dB;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   bothOn = 0;
  exp_t sbq[$];
  exp_t curExp;

  sram_phase_sequencer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ABITS(ABITS)) bus ();

  sram_phase_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ABITS(ABITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.ReadEn === 1'b1 && bus.WriteEn === 1'b1) bothOn++;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] oh(input int a);
    return 32'h1 << a;
  endfunction

  task automatic waitReady(input string tag);
    int n;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL %s_ready_timeout got=%b exp=1", tag, bus.req_ready);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({bus.wordA, bus.wordB, bus.in, bus.ReadEn, bus.WriteEn, bus.rsp_valid, bus.rsp_dataA,
         bus.rsp_dataB, bus.wr_done, bus.req_ready, bus.phase} !== '0) begin
      failures++; $display("FAIL reset_outputs got wordA=%h ready=%b phase=%0d exp all zero",
                           bus.wordA, bus.req_ready, bus.phase);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_release_ready got=%b exp=1", bus.req_ready);
    end
    checks++;
    if (bus.phase !== 4'd0) begin
      failures++; $display("FAIL reset_release_phase got=%0d exp=0", bus.phase);
    end
  endtask

  task automatic test_write();
    exp_t e;
    logic [31:0] eA, eB;
    eA = oh(1);
    eB = BEN ? oh(31) : 32'h0;
    waitReady("write");
    bus.req_write = 1'b1; bus.req_addrA = 5'd1; bus.req_addrB = 5'd31;
    bus.req_data = 16'hAAAA; bus.req_valid = 1'b1;
    e.isWrite = 1'b1; e.dA = '0; e.dB = '0; sbq.push_back(e);
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_data = 16'h5555; bus.req_addrA = 5'd9; bus.req_addrB = 5'd9;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      checks++;
      if (bus.phase !== 4'(k)) begin
        failures++; $display("FAIL write_phase got=%0d exp=%0d", bus.phase, k);
      end
      checks++;
      if (bus.wordA !== ((k >= 2 && k <= 8) ? eA : 32'h0)) begin
        failures++; $display("FAIL write_wordA phase=%0d got=%h", k, bus.wordA);
      end
      checks++;
      if (bus.wordB !== ((k >= 2 && k <= 8) ? eB : 32'h0)) begin
        failures++; $display("FAIL write_wordB phase=%0d got=%h", k, bus.wordB);
      end
      checks++;
      if (bus.in !== ((k >= 4 && k <= 8) ? 16'hAAAA : 16'h0)) begin
        failures++; $display("FAIL write_in phase=%0d got=%h", k, bus.in);
      end
      checks++;
      if (bus.WriteEn !== (k == 8) || bus.ReadEn !== 1'b0) begin
        failures++; $display("FAIL write_enables phase=%0d got we=%b re=%b", k, bus.WriteEn, bus.ReadEn);
      end
      checks++;
      if (bus.req_ready !== 1'b0 || bus.wr_done !== 1'b0) begin
        failures++; $display("FAIL write_busy phase=%0d got ready=%b done=%b exp 0 0", k, bus.req_ready, bus.wr_done);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (bus.wr_done === 1'b1) begin
      if (sbq.size() == 0) begin
        failures++; $display("FAIL write_sb_empty got=0 entries exp=1");
      end else begin
        e = sbq.pop_front();
        if (e.isWrite !== 1'b1) begin
          failures++; $display("FAIL write_sb_kind got=read exp=write");
        end
      end
    end else begin
      failures++; $display("FAIL write_wr_done got=%b exp=1 (11 cycles after accept)", bus.wr_done);
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL write_idle_ready got=%b exp=1", bus.req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.wr_done !== 1'b0) begin
      failures++; $display("FAIL write_done_pulse got=%b exp=0", bus.wr_done);
    end
  endtask

  task automatic test_read();
    exp_t e;
    logic [31:0] eA, eB;
    eA = oh(5);
    eB = BEN ? oh(2) : 32'h0;
    waitReady("read");
    bus.outA = 16'hDEAD; bus.outB = 16'hBEEF; bus.rsp_ready = 1'b0;
    bus.req_write = 1'b0; bus.req_addrA = 5'd5; bus.req_addrB = 5'd2;
    bus.req_data = 16'h7777; bus.req_valid = 1'b1;
    e.isWrite = 1'b0; e.dA = 16'hABCD; e.dB = BEN ? 16'h1234 : 16'h0; sbq.push_back(e);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      checks++;
      if (bus.phase !== 4'(k)) begin
        failures++; $display("FAIL read_phase got=%0d exp=%0d", bus.phase, k);
      end
      checks++;
      if (bus.ReadEn !== (k == 6 || k == 7) || bus.WriteEn !== 1'b0) begin
        failures++; $display("FAIL read_enables phase=%0d got re=%b we=%b", k, bus.ReadEn, bus.WriteEn);
      end
      checks++;
      if (bus.wordA !== ((k >= 2 && k <= 8) ? eA : 32'h0) ||
          bus.wordB !== ((k >= 2 && k <= 8) ? eB : 32'h0)) begin
        failures++; $display("FAIL read_words phase=%0d got A=%h B=%h", k, bus.wordA, bus.wordB);
      end
      checks++;
      if (bus.in !== 16'h0 || bus.rsp_valid !== 1'b0) begin
        failures++; $display("FAIL read_in_rsp phase=%0d got in=%h rv=%b exp 0 0", k, bus.in, bus.rsp_valid);
      end
      if (k == 7) begin bus.outA = 16'hABCD; bus.outB = 16'h1234; end
      if (k == 8) begin bus.outA = 16'hDEAD; bus.outB = 16'hBEEF; end
    end
    @(posedge clk); #1;
    checks++;
    if (bus.rsp_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        failures++; $display("FAIL read_sb_empty got=0 entries exp=1");
      end else begin
        curExp = sbq.pop_front();
        if (curExp.isWrite !== 1'b0 || bus.rsp_dataA !== curExp.dA || bus.rsp_dataB !== curExp.dB) begin
          failures++; $display("FAIL read_rsp_data got A=%h B=%h exp A=%h B=%h",
                               bus.rsp_dataA, bus.rsp_dataB, curExp.dA, curExp.dB);
        end
      end
    end else begin
      failures++; $display("FAIL read_rsp_valid got=%b exp=1", bus.rsp_valid);
    end
  endtask

  task automatic test_resp_backpressure();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_dataA !== curExp.dA || bus.rsp_dataB !== curExp.dB) begin
        failures++; $display("FAIL hold_rsp cycle=%0d got rv=%b A=%h B=%h exp 1 %h %h",
                             i, bus.rsp_valid, bus.rsp_dataA, bus.rsp_dataB, curExp.dA, curExp.dB);
      end
      checks++;
      if (bus.req_ready !== 1'b0) begin
        failures++; $display("FAIL hold_ready cycle=%0d got=%b exp=0", i, bus.req_ready);
      end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL hold_release got rv=%b ready=%b exp 0 1", bus.rsp_valid, bus.req_ready);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    waitReady("reset_mid");
    bus.req_write = 1'b0; bus.req_addrA = 5'd9; bus.req_addrB = 5'd4; bus.req_valid = 1'b1;
    bus.outA = 16'h4321; bus.outB = 16'h8765;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin @(posedge clk); #1; end
    checks++;
    if (bus.phase !== 4'd6 || bus.ReadEn !== 1'b1) begin
      failures++; $display("FAIL mid_phase6 got phase=%0d re=%b exp 6 1", bus.phase, bus.ReadEn);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.wordA, bus.wordB, bus.in, bus.ReadEn, bus.WriteEn, bus.rsp_valid, bus.rsp_dataA,
         bus.rsp_dataB, bus.wr_done, bus.req_ready, bus.phase} !== '0) begin
      failures++; $display("FAIL mid_reset_outputs got wordA=%h re=%b dataA=%h phase=%0d exp all zero",
                           bus.wordA, bus.ReadEn, bus.rsp_dataA, bus.phase);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL mid_release_ready got=%b exp=1", bus.req_ready);
    end
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid !== 1'b0 || bus.wr_done !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++; $display("FAIL mid_abandon got=%0d response cycles exp=0", seen);
    end
  endtask

  task automatic test_same_addr();
    exp_t e;
    int got;
    waitReady("same_w");
    bus.req_write = 1'b1; bus.req_addrA = 5'd0; bus.req_addrB = 5'd0;
    bus.req_data = 16'h0F0F; bus.req_valid = 1'b1;
    e.isWrite = 1'b1; e.dA = '0; e.dB = '0; sbq.push_back(e);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1; @(posedge clk); #1;
    checks++;
    if (bus.phase !== 4'd2 || bus.wordA !== 32'h1 || bus.wordB !== (BEN ? 32'h1 : 32'h0)) begin
      failures++; $display("FAIL same_words got phase=%0d A=%h B=%h exp 2 1 %h",
                           bus.phase, bus.wordA, bus.wordB, BEN ? 32'h1 : 32'h0);
    end
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      @(posedge clk); #1;
      if (bus.wr_done === 1'b1) got = 1;
    end
    checks++;
    if (got == 0 || sbq.size() == 0) begin
      failures++; $display("FAIL same_wr_done got=%0d exp=1", got);
    end else begin
      e = sbq.pop_front();
      if (e.isWrite !== 1'b1) begin
        failures++; $display("FAIL same_sb_kind got=read exp=write");
      end
    end
    waitReady("same_r");
    bus.req_write = 1'b0; bus.req_addrA = 5'd7; bus.req_addrB = 5'd3; bus.req_valid = 1'b1;
    bus.outA = 16'h1111; bus.outB = 16'h2222;
    e.isWrite = 1'b0; e.dA = 16'h1111; e.dB = BEN ? 16'h2222 : 16'h0; sbq.push_back(e);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin @(posedge clk); #1; end
    checks++;
    if (bus.wordA !== oh(7) || bus.wordB !== (BEN ? oh(3) : 32'h0)) begin
      failures++; $display("FAIL addrB_word got A=%h B=%h exp %h %h", bus.wordA, bus.wordB,
                           oh(7), BEN ? oh(3) : 32'h0);
    end
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid === 1'b1) got = 1;
    end
    checks++;
    if (got == 0 || sbq.size() == 0) begin
      failures++; $display("FAIL addrB_rsp_valid got=%0d exp=1", got);
    end else begin
      e = sbq.pop_front();
      if (bus.rsp_dataA !== e.dA || bus.rsp_dataB !== e.dB) begin
        failures++; $display("FAIL addrB_rsp_data got A=%h B=%h exp A=%h B=%h",
                             bus.rsp_dataA, bus.rsp_dataB, e.dA, e.dB);
      end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int accCyc[5];
    int nAcc, cyc, got;
    waitReady("b2b");
    bus.req_write = 1'b1; bus.req_addrA = 5'd12; bus.req_addrB = 5'd20;
    bus.req_data = 16'h3C3C; bus.req_valid = 1'b1;
    nAcc = 0; cyc = 0;
    while (nAcc < 5 && cyc < 100) begin
      if (bus.wr_done === 1'b1) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++; $display("FAIL b2b_sb_empty cycle=%0d got=0 entries exp>=1", cyc);
        end else begin
          e = sbq.pop_front();
          if (e.isWrite !== 1'b1) begin
            failures++; $display("FAIL b2b_sb_kind got=read exp=write");
          end
        end
      end
      if (bus.req_ready === 1'b1) begin
        accCyc[nAcc] = cyc; nAcc++;
        e.isWrite = 1'b1; e.dA = '0; e.dB = '0; sbq.push_back(e);
      end
      @(posedge clk); #1; cyc++;
    end
    bus.req_valid = 1'b0;
    checks++;
    if (nAcc != 5) begin
      failures++; $display("FAIL b2b_accepts got=%0d exp=5", nAcc);
    end
    for (int i = 1; i < nAcc; i++) begin
      checks++;
      if (accCyc[i] - accCyc[i-1] != 11) begin
        failures++; $display("FAIL b2b_interval idx=%0d got=%0d exp=11", i, accCyc[i] - accCyc[i-1]);
      end
    end
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      @(posedge clk); #1;
      if (bus.wr_done === 1'b1) got = 1;
    end
    checks++;
    if (got == 0 || sbq.size() == 0) begin
      failures++; $display("FAIL b2b_last_done got=%0d exp=1", got);
    end else begin
      e = sbq.pop_front();
    end
    checks++;
    if (bothOn != 0) begin
      failures++; $display("FAIL both_enables got=%0d cycles exp=0", bothOn);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addrA = '0; bus.req_addrB = '0;
    bus.req_data = '0; bus.outA = '0; bus.outB = '0; bus.rsp_ready = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_resp_backpressure();
    test_reset_mid();
    test_same_addr();
    test_back_to_back();
    checks++;
    if (sbq.size() != 0) begin
      failures++; $display("FAIL sb_leftover got=%0d entries exp=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
